// File: rtl/eth_pkg.sv
// Shared constants and FSM state type for the Ethernet frame receiver.
package eth_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PREAMBLE,
        HEADER,
        PAYLOAD,
        DROP
    } rx_state_t;

    localparam logic [7:0]  ETH_PREAMBLE    = 8'h55;
    localparam logic [7:0]  ETH_SFD         = 8'hD5;
    localparam logic [47:0] ETH_BCAST       = 48'hFFFF_FFFF_FFFF;
    localparam logic [31:0] ETH_CRC_RESIDUE = 32'hC704DD7B;
    localparam logic [31:0] ETH_CRC_POLY    = 32'h04C11DB7;
    localparam int          ETH_HDR_LEN     = 14;
    localparam int          ETH_MIN_LEN     = 64;

endpackage

// File: rtl/crc32_d8.sv
// Combinational byte-wide CRC-32 step, wire bit order (LSB of each byte first).
module crc32_d8
    import eth_pkg::*;
(
    input  logic [31:0] crc,
    input  logic [7:0]  data,
    output logic [31:0] crc_next
);

    // Non-reflected register fed LSB-first, so the good-frame residue reads 0xC704DD7B.
    always_comb begin
        crc_next = crc;
        for (int i = 0; i < 8; i++) begin
            if (crc_next[31] ^ data[i])
                crc_next = {crc_next[30:0], 1'b0} ^ ETH_CRC_POLY;
            else
                crc_next = {crc_next[30:0], 1'b0};
        end
    end

endmodule

// File: rtl/eth_frame_rx.sv
// RMII-side Ethernet frame receiver: preamble/SFD sync, header capture, DA filter, FCS strip.
// Define ETH_RX_FCS_CHECK_EN to build the CRC-32 check into frame_ok.
module eth_frame_rx
    import eth_pkg::*;
#(
    parameter logic [47:0] MAC_ADDR = 48'h02_00_00_00_00_01,
    parameter int          MAX_LEN  = 1518
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_valid,
    input  logic [7:0]  rx_byte,
    input  logic        rx_byte_valid,
    output logic [47:0] dst_mac,
    output logic [47:0] src_mac,
    output logic [15:0] ethertype,
    output logic        hdr_valid,
    output logic [7:0]  payload_byte,
    output logic        payload_valid,
    output logic        frame_done,
    output logic        frame_ok,
    output logic [10:0] frame_len
);

    localparam logic [10:0] MIN_LEN_L = 11'(ETH_MIN_LEN);
    localparam logic [10:0] MAX_LEN_L = 11'(MAX_LEN);
    localparam logic [3:0]  HDR_LAST  = 4'(ETH_HDR_LEN - 1);

    rx_state_t        state;
    logic [3:0]       hdr_cnt;
    logic [10:0]      len_cnt;
    logic [3:0][7:0]  dly;
    logic [2:0]       dly_cnt;
    logic             fcs_ok;
    logic             eof;
    logic             len_ok;
    logic             sfd_seen;
    logic [47:0]      dst_next;

    assign eof      = !data_valid && !rx_byte_valid;
    assign len_ok   = (len_cnt >= MIN_LEN_L) && (len_cnt <= MAX_LEN_L);
    assign sfd_seen = (state == PREAMBLE) && rx_byte_valid && (rx_byte == ETH_SFD);
    assign dst_next = {dst_mac[39:0], rx_byte};

`ifdef ETH_RX_FCS_CHECK_EN
    logic [31:0] crc;
    logic [31:0] crc_next;

    crc32_d8 u_crc32_d8 (
        .crc      (crc),
        .data     (rx_byte),
        .crc_next (crc_next)
    );

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            crc <= '1;
        else if (sfd_seen)
            crc <= '1;
        else if (rx_byte_valid && (state inside {HEADER, PAYLOAD}))
            crc <= crc_next;
    end

    assign fcs_ok = (crc == ETH_CRC_RESIDUE);
`else
    assign fcs_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state         <= IDLE;
            hdr_cnt       <= '0;
            len_cnt       <= '0;
            // NOTE: the delay line is a handful of flops, not a RAM, so it is cleared on reset like any register.
            dly           <= '0;
            dly_cnt       <= '0;
            dst_mac       <= '0;
            src_mac       <= '0;
            ethertype     <= '0;
            hdr_valid     <= 1'b0;
            payload_byte  <= '0;
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;
            frame_len     <= '0;
        end else begin
            hdr_valid     <= 1'b0;
            payload_valid <= 1'b0;
            frame_done    <= 1'b0;
            frame_ok      <= 1'b0;

            if (rx_byte_valid && (state inside {HEADER, PAYLOAD}) && (len_cnt != 11'h7FF))
                len_cnt <= len_cnt + 11'd1;

            case (state)
                IDLE: begin
                    if (rx_byte_valid && rx_byte == ETH_PREAMBLE)
                        state <= PREAMBLE;
                end
                PREAMBLE: begin
                    if (sfd_seen) begin
                        state   <= HEADER;
                        hdr_cnt <= '0;
                        len_cnt <= '0;
                        dly     <= '0;
                        dly_cnt <= '0;
                    end else if (rx_byte_valid && rx_byte != ETH_PREAMBLE) begin
                        state <= DROP;
                    end else if (eof) begin
                        state <= IDLE;
                    end
                end
                HEADER: begin
                    if (rx_byte_valid) begin
                        hdr_cnt <= hdr_cnt + 4'd1;
                        if (hdr_cnt < 4'd6)
                            dst_mac <= dst_next;
                        else if (hdr_cnt < 4'd12)
                            src_mac <= {src_mac[39:0], rx_byte};
                        else
                            ethertype <= {ethertype[7:0], rx_byte};
                        // Destination filter decides as soon as the sixth address byte lands.
                        if (hdr_cnt == 4'd5 && dst_next != MAC_ADDR && dst_next != ETH_BCAST)
                            state <= DROP;
                        if (hdr_cnt == HDR_LAST) begin
                            hdr_valid <= 1'b1;
                            state     <= PAYLOAD;
                        end
                    end else if (eof) begin
                        frame_done <= 1'b1;
                        frame_ok   <= 1'b0;
                        frame_len  <= len_cnt;
                        state      <= IDLE;
                    end
                end
                PAYLOAD: begin
                    // Four-byte lag keeps the trailing FCS from ever reaching payload_byte.
                    if (rx_byte_valid) begin
                        dly <= {dly[2:0], rx_byte};
                        if (dly_cnt == 3'd4) begin
                            payload_byte  <= dly[3];
                            payload_valid <= 1'b1;
                        end else begin
                            dly_cnt <= dly_cnt + 3'd1;
                        end
                    end else if (eof) begin
                        frame_done <= 1'b1;
                        frame_ok   <= len_ok && fcs_ok;
                        frame_len  <= len_cnt;
                        state      <= IDLE;
                    end
                end
                DROP: begin
                    if (eof)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_eth_frame_rx.sv
// Directed, table-driven bench for eth_frame_rx with an independent reflected CRC-32 FCS generator.
module tb_eth_frame_rx;
    import eth_pkg::*;

    localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
    localparam logic [47:0] SRC = 48'h02_00_00_00_00_02;
    localparam logic [47:0] BAD = 48'h02_00_00_00_00_99;
`ifdef ETH_RX_FCS_CHECK_EN
    localparam logic FCS_EN = 1'b1;
`else
    localparam logic FCS_EN = 1'b0;
`endif

    logic        clk;
    logic        resetn;
    logic        data_valid;
    logic [7:0]  rx_byte;
    logic        rx_byte_valid;
    logic [47:0] dst_mac;
    logic [47:0] src_mac;
    logic [15:0] ethertype;
    logic        hdr_valid;
    logic [7:0]  payload_byte;
    logic        payload_valid;
    logic        frame_done;
    logic        frame_ok;
    logic [10:0] frame_len;

    eth_frame_rx #(.MAC_ADDR(MAC), .MAX_LEN(1518)) dut (
        .clk           (clk),
        .resetn        (resetn),
        .data_valid    (data_valid),
        .rx_byte       (rx_byte),
        .rx_byte_valid (rx_byte_valid),
        .dst_mac       (dst_mac),
        .src_mac       (src_mac),
        .ethertype     (ethertype),
        .hdr_valid     (hdr_valid),
        .payload_byte  (payload_byte),
        .payload_valid (payload_valid),
        .frame_done    (frame_done),
        .frame_ok      (frame_ok),
        .frame_len     (frame_len)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] frm [0:2199];
    int         frm_len;
    int         exp_pay_n;

    int          n_hdr;
    int          pay_seen;
    int          pay_err;
    int          n_done;
    logic        got_ok;
    logic [10:0] got_len;

    typedef struct {
        logic [47:0] dst;
        logic [15:0] etype;
        int          pay_n;
        int          flip;
        logic        exp_ok;
        logic [10:0] exp_len;
        int          exp_hdr;
        int          exp_pay;
        int          exp_done;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (hdr_valid)
            n_hdr++;
        if (payload_valid) begin
            if (pay_seen >= exp_pay_n || payload_byte != frm[14 + pay_seen])
                pay_err++;
            pay_seen++;
        end
        if (frame_done) begin
            n_done++;
            got_ok  = frame_ok;
            got_len = frame_len;
        end
    end

    task automatic clear_mon();
        n_hdr    = 0;
        pay_seen = 0;
        pay_err  = 0;
        n_done   = 0;
        got_ok   = 1'b0;
        got_len  = '0;
    endtask

    // Standard Ethernet FCS: reflected CRC-32, init all-ones, complemented, sent LSB byte first.
    function automatic logic [31:0] fcs_of(input int n);
        logic [31:0] c;
        c = '1;
        for (int i = 0; i < n; i++) begin
            c = c ^ {24'b0, frm[i]};
            for (int b = 0; b < 8; b++)
                c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
        end
        return ~c;
    endfunction

    task automatic build_frame(input logic [47:0] dst, input logic [15:0] etype,
                               input int pay_n, input int flip);
        logic [31:0] fcs;
        for (int i = 0; i < 6; i++) begin
            frm[i]     = dst[47 - 8*i -: 8];
            frm[6 + i] = SRC[47 - 8*i -: 8];
        end
        frm[12] = etype[15:8];
        frm[13] = etype[7:0];
        for (int i = 0; i < pay_n; i++)
            frm[14 + i] = 8'(i);
        fcs = fcs_of(14 + pay_n);
        for (int i = 0; i < 4; i++)
            frm[14 + pay_n + i] = fcs[8*i +: 8];
        if (flip >= 0)
            frm[14 + flip] = frm[14 + flip] ^ 8'h01;
        frm_len   = 18 + pay_n;
        exp_pay_n = pay_n;
    endtask

    task automatic put_byte(input logic [7:0] b, input logic dv);
        @(posedge clk); #1;
        rx_byte       = b;
        rx_byte_valid = 1'b1;
        data_valid    = dv;
        @(posedge clk); #1;
        rx_byte_valid = 1'b0;
    endtask

    task automatic end_frame();
        @(posedge clk); #1;
        data_valid = 1'b0;
        repeat (12) @(posedge clk);
    endtask

    task automatic send_frame(input logic last_dv);
        repeat (7) put_byte(ETH_PREAMBLE, 1'b1);
        put_byte(ETH_SFD, 1'b1);
        for (int i = 0; i < frm_len; i++)
            put_byte(frm[i], (i == frm_len - 1) ? last_dv : 1'b1);
        end_frame();
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_hdr_fields"}, {dst_mac, src_mac, ethertype}, '0);
        check({name, "_strobes"}, {hdr_valid, payload_valid, frame_done, frame_ok}, '0);
        check({name, "_payload_byte"}, 128'(payload_byte), '0);
        check({name, "_frame_len"}, 128'(frame_len), '0);
    endtask

    initial begin
        vecs[0] = '{MAC,       16'h0800,   46, -1, 1'b1,    11'd64,   1,   46, 1};
        vecs[1] = '{MAC,       16'h0800,   46, 10, ~FCS_EN, 11'd64,   1,   46, 1};
        vecs[2] = '{BAD,       16'h0800,   46, -1, 1'b0,    11'd0,    0,    0, 0};
        vecs[3] = '{MAC,       16'h0800,   46, -1, 1'b1,    11'd64,   1,   46, 1};
        vecs[4] = '{ETH_BCAST, 16'h0806,   42, -1, 1'b0,    11'd60,   1,   42, 1};
        vecs[5] = '{MAC,       16'h0800, 1501, -1, 1'b0,    11'd1519, 1, 1501, 1};
        vecs[6] = '{MAC,       16'h0800, 1500, -1, 1'b1,    11'd1518, 1, 1500, 1};
        vecs[7] = '{MAC,       16'h0800, 2100, -1, 1'b0,    11'd2047, 1, 2100, 1};

        resetn        = 1'b0;
        data_valid    = 1'b0;
        rx_byte       = '0;
        rx_byte_valid = 1'b0;
        exp_pay_n     = 0;
        clear_mon();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_outputs_zero("reset");
        @(posedge clk); #1;
        resetn = 1'b1;

        for (int v = 0; v < 8; v++) begin
            build_frame(vecs[v].dst, vecs[v].etype, vecs[v].pay_n, vecs[v].flip);
            clear_mon();
            send_frame(1'b1);
            check($sformatf("v%0d_hdr_valid_count", v), 128'(n_hdr), 128'(vecs[v].exp_hdr));
            check($sformatf("v%0d_payload_count", v), 128'(pay_seen), 128'(vecs[v].exp_pay));
            check($sformatf("v%0d_payload_errors", v), 128'(pay_err), 128'(0));
            check($sformatf("v%0d_frame_done_count", v), 128'(n_done), 128'(vecs[v].exp_done));
            check($sformatf("v%0d_frame_ok", v), 128'(got_ok), 128'(vecs[v].exp_ok));
            check($sformatf("v%0d_frame_len", v), 128'(got_len), 128'(vecs[v].exp_len));
            if (v == 0) begin
                check("v0_dst_mac_held", 128'(dst_mac), 128'(MAC));
                check("v0_src_mac_held", 128'(src_mac), 128'(SRC));
                check("v0_ethertype_held", 128'(ethertype), 128'(16'h0800));
            end
            if (v == 4) begin
                check("v4_dst_mac_bcast", 128'(dst_mac), 128'(ETH_BCAST));
                check("v4_ethertype", 128'(ethertype), 128'(16'h0806));
            end
        end

        // Broken preamble: a valid SFD and header afterwards must not be picked up.
        build_frame(MAC, 16'h0800, 46, -1);
        clear_mon();
        put_byte(ETH_PREAMBLE, 1'b1);
        put_byte(ETH_PREAMBLE, 1'b1);
        put_byte(8'h12, 1'b1);
        put_byte(ETH_SFD, 1'b1);
        for (int i = 0; i < 20; i++)
            put_byte(frm[i], 1'b1);
        end_frame();
        check("badpre_hdr_valid_count", 128'(n_hdr), 128'(0));
        check("badpre_frame_done_count", 128'(n_done), 128'(0));
        clear_mon();
        send_frame(1'b1);
        check("after_badpre_frame_done_count", 128'(n_done), 128'(1));
        check("after_badpre_frame_ok", 128'(got_ok), 128'(1));

        // Last FCS byte strobed while data_valid is already low.
        clear_mon();
        send_frame(1'b0);
        check("late_byte_frame_done_count", 128'(n_done), 128'(1));
        check("late_byte_frame_ok", 128'(got_ok), 128'(1));
        check("late_byte_frame_len", 128'(got_len), 128'(64));
        check("late_byte_payload_count", 128'(pay_seen), 128'(46));

        // Reset after payload byte 20 abandons the frame.
        clear_mon();
        repeat (7) put_byte(ETH_PREAMBLE, 1'b1);
        put_byte(ETH_SFD, 1'b1);
        for (int i = 0; i < 34; i++)
            put_byte(frm[i], 1'b1);
        resetn = 1'b0;
        @(negedge clk);
        check_outputs_zero("midreset");
        @(posedge clk); #1;
        resetn = 1'b1;
        clear_mon();
        for (int i = 34; i < 44; i++)
            put_byte(frm[i], 1'b1);
        end_frame();
        check("postreset_hdr_valid_count", 128'(n_hdr), 128'(0));
        check("postreset_payload_count", 128'(pay_seen), 128'(0));
        check("postreset_frame_done_count", 128'(n_done), 128'(0));
        @(negedge clk);
        check_outputs_zero("postreset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
